// File: rtl/fifo_word_packer_if.sv
// rtl/fifo_word_packer_if.sv - FIFO drain side and packed-word stream of fifo_word_packer
interface fifo_word_packer_if #(
  parameter int width = 8,
  parameter int ratio = 4
);
  localparam int CW = $clog2(ratio) + 1;

  logic [width-1:0]       fifo_dout;
  logic                   fifo_empty;
  logic                   fifo_read_en;
  logic [width*ratio-1:0] out_data;
  logic [CW-1:0]          out_count;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    input  fifo_dout, fifo_empty, out_ready,
    output fifo_read_en, out_data, out_count, out_valid
  );

  modport slave (
    output fifo_dout, fifo_empty, out_ready,
    input  fifo_read_en, out_data, out_count, out_valid
  );
endinterface

// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - packs ratio show-ahead FIFO words into one wide word
// Optional idle-timeout partial flush is built when PACKER_FLUSH_EN is defined.
module fifo_word_packer #(
  parameter int width   = 8,
  parameter int ratio   = 4,
  parameter int timeout = 15
) (
  input  logic clk,
  input  logic reset_n,
  fifo_word_packer_if.master bus
);
  localparam int IW = $clog2(ratio);
  localparam int CW = $clog2(ratio) + 1;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  if (ratio < 2 || timeout < 1) begin : g_bad_param
    $error("fifo_word_packer: ratio must be >= 2 and timeout >= 1");
  end

  logic [0:0]             state;
  logic [IW-1:0]          idx;
  logic [width*ratio-1:0] data_q;
  logic [CW-1:0]          count_q;
  logic                   valid_q;
  logic                   pop;
  logic                   last;

  assign pop  = (state == FILL) && !bus.fifo_empty && reset_n;
  assign last = (idx == IW'(ratio - 1));

  assign bus.fifo_read_en = pop;
  assign bus.out_data     = data_q;
  assign bus.out_count    = count_q;
  assign bus.out_valid    = valid_q;

`ifdef PACKER_FLUSH_EN
  localparam int TW = $clog2(timeout + 1);

  logic [TW-1:0] idle;
  logic          idle_cyc;
  logic          flush;

  // A flush fires on the edge where the idle count would reach timeout.
  assign idle_cyc = (state == FILL) && !pop && (idx != '0);
  assign flush    = idle_cyc && (idle == TW'(timeout - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle <= '0;
    end else if (pop || flush || state == HOLD) begin
      idle <= '0;
    end else if (idle_cyc) begin
      idle <= idle + TW'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= FILL;
      idx     <= '0;
      data_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (pop) begin
            data_q[idx*width +: width] <= bus.fifo_dout;
            if (last) begin
              state   <= HOLD;
              count_q <= CW'(ratio);
              valid_q <= 1'b1;
              idx     <= '0;
            end else begin
              idx <= idx + IW'(1);
            end
          end
`ifdef PACKER_FLUSH_EN
          else if (flush) begin
            state   <= HOLD;
            count_q <= CW'(idx);
            valid_q <= 1'b1;
            idx     <= '0;
          end
`endif
        end
        HOLD: begin
          if (bus.out_ready) begin
            state   <= FILL;
            data_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_word_packer.sv
// tb/tb_fifo_word_packer.sv - self-checking bench for fifo_word_packer
// Honours PACKER_FLUSH_EN for the flush expectations.
module tb_fifo_word_packer;
  localparam int W  = 8;
  localparam int R  = 4;
  localparam int T  = 15;
  localparam int CW = $clog2(R) + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  fifo_word_packer_if #(.width(W), .ratio(R)) bus ();

  fifo_word_packer #(.width(W), .ratio(R), .timeout(T)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]   fq[$];
  logic [W-1:0]   pq[$];
  logic [W*R-1:0] got[$];
  logic [CW-1:0]  got_cnt[$];

  bit             held;
  logic [W*R-1:0] held_data;
  int             held_count;
  int             idle;
  bit             rdy;
  int             vcycles;
  int             rd_pulses;
  int             cyc;
  int             first_valid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W*R-1:0] pack_words();
    logic [W*R-1:0] d = '0;
    foreach (pq[i]) d[i*W +: W] = pq[i];
    return d;
  endfunction

  function automatic logic [63:0] got_at(input int i);
    return (got.size() > i) ? 64'(got[i]) : 'x;
  endfunction

  function automatic logic [63:0] cnt_at(input int i);
    return (got_cnt.size() > i) ? 64'(got_cnt[i]) : 'x;
  endfunction

  task automatic emit(input int n);
    held       = 1'b1;
    held_count = n;
    held_data  = pack_words();
    pq.delete();
    idle       = 0;
  endtask

  task automatic clear_obs();
    got.delete();
    got_cnt.delete();
    vcycles     = 0;
    rd_pulses   = 0;
    first_valid = -1;
  endtask

  // One clock cycle: drive FIFO/consumer, check outputs against the model, advance the model.
  task automatic step();
    bit exp_rd;
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_dout  = (fq.size() > 0) ? fq[0] : '0;
    bus.out_ready  = rdy;
    @(negedge clk);
    exp_rd = !held && (fq.size() > 0) && reset_n;
    chk("read_en", 64'(bus.fifo_read_en), 64'(exp_rd));
    chk("out_valid", 64'(bus.out_valid), 64'(held));
    if (bus.fifo_read_en) rd_pulses++;
    if (bus.out_valid && first_valid < 0) first_valid = cyc;
    if (held) begin
      chk("out_data", 64'(bus.out_data), 64'(held_data));
      chk("out_count", 64'(bus.out_count), 64'(held_count));
      vcycles++;
    end
    if (held && rdy) begin
      got.push_back(bus.out_data);
      got_cnt.push_back(bus.out_count);
      held = 1'b0;
      idle = 0;
    end else if (exp_rd) begin
      pq.push_back(fq.pop_front());
      idle = 0;
      if (pq.size() == R) emit(R);
    end else if (!held && pq.size() > 0) begin
`ifdef PACKER_FLUSH_EN
      idle++;
      if (idle == T) emit(pq.size());
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    pq.delete();
    held = 1'b0;
    idle = 0;
    #1;
    chk("rst_read_en", 64'(bus.fifo_read_en), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_out_count", 64'(bus.out_count), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int s0;
    held = 1'b0; idle = 0; cyc = 0; rdy = 1'b1;
    clear_obs();
    bus.fifo_empty = 1'b0;
    bus.fifo_dout  = 8'h99;
    bus.out_ready  = 1'b1;

    // Reset with the FIFO non-empty
    fq.push_back(8'h99);
    #2;
    do_reset();
    fq.delete();

    // Basic pack
    clear_obs();
    rdy = 1'b1;
    fq = {8'h11, 8'h22, 8'h33, 8'h44};
    run(8);
    chk("basic_pulses", 64'(rd_pulses), 64'(4));
    chk("basic_valid_cycles", 64'(vcycles), 64'(1));
    chk("basic_data", got_at(0), 64'h44332211);
    chk("basic_count", cnt_at(0), 64'(4));

    // Backpressure
    clear_obs();
    rdy = 1'b0;
    for (int i = 1; i <= 8; i++) fq.push_back(W'(i));
    run(20);
    chk("bp_pulses", 64'(rd_pulses), 64'(4));
    chk("bp_valid_cycles", 64'(vcycles), 64'(16));
    chk("bp_fifo_left", 64'(fq.size()), 64'(4));
    rdy = 1'b1;
    run(10);
    chk("bp_first", got_at(0), 64'h04030201);
    chk("bp_second", got_at(1), 64'h08070605);

    // Partial word / idle flush
    clear_obs();
    s0 = cyc;
    fq = {8'hAA, 8'hBB};
`ifdef PACKER_FLUSH_EN
    run(22);
    chk("flush_data", got_at(0), 64'h0000BBAA);
    chk("flush_count", cnt_at(0), 64'(2));
    chk("flush_cycle", 64'(first_valid - s0), 64'(17));
`else
    run(100);
    chk("noflush_packets", 64'(got.size()), 64'(0));
    chk("noflush_valid", 64'(vcycles), 64'(0));
    fq = {8'hCC, 8'hDD};
    run(4);
    chk("noflush_data", got_at(0), 64'hDDCCBBAA);
    chk("noflush_count", cnt_at(0), 64'(4));
`endif

    // Slow trickle restarts the idle timer
    clear_obs();
    for (int i = 0; i < 4; i++) begin
      fq.push_back(W'(8'h71 + i));
      run(10);
    end
    chk("trickle_packets", 64'(got.size()), 64'(1));
    chk("trickle_data", got_at(0), 64'h74737271);
    chk("trickle_count", cnt_at(0), 64'(4));

    // Reset mid-fill
    clear_obs();
    fq = {8'h61, 8'h62, 8'h63};
    run(3);
    do_reset();
    fq = {8'h51, 8'h52, 8'h53, 8'h54};
    run(6);
    chk("midrst_packets", 64'(got.size()), 64'(1));
    chk("midrst_data", got_at(0), 64'h54535251);
    chk("midrst_count", cnt_at(0), 64'(4));

    // Random traffic and backpressure against the model
    clear_obs();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2) == 0) fq.push_back(W'($urandom));
      rdy = ($urandom_range(3) != 0);
      step();
    end
`ifndef PACKER_FLUSH_EN
    foreach (got_cnt[i]) chk("rand_count", 64'(got_cnt[i]), 64'(R));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Downstream drain stage for `parameterized_fifo`. It pops narrow words from the FIFO's show-ahead read port and packs `ratio` consecutive words into one wide word. The wide word is presented on a valid/ready output for the next consumer. An optional idle-timeout flush emits partially filled words so trailing data never stalls.

## Interface

Parameters:
- `width`, 8: FIFO word width in bits.
- `ratio`, 4: narrow words per output word; must be ≥ 2.
- `timeout`, 15: idle cycles before a partial word is flushed. Used only with `PACKER_FLUSH_EN`; must be ≥ 1.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `fifo_dout` input `width`: FIFO head word. It is valid in the same cycle whenever `fifo_empty`=0.
- `fifo_empty` input 1: FIFO empty flag.
- `fifo_read_en` output 1: pop request, wired to the FIFO's `read_en`.
- `out_data` output `width*ratio`: packed word. Lane 0 (bits `width-1:0`) holds the first word popped.
- `out_count` output `$clog2(ratio)+1`: number of valid lanes in `out_data`, range 1..`ratio`.
- `out_valid` output 1: `out_data` and `out_count` are valid.
- `out_ready` input 1: consumer accepts the word in any cycle where `out_valid`=1 and `out_ready`=1.

## Operation

- The FSM has two states: FILL and HOLD.
- Lane index `idx` runs 0..`ratio-1`. Timer `idle` is `$clog2(timeout+1)` bits wide.
- Pop logic:
  - `fifo_read_en` = (state==FILL) && !`fifo_empty` && `reset_n`. It is combinational.
  - A pop occurs in any cycle where `fifo_read_en`=1.
- FILL:
  - On a pop, `fifo_dout` is written into lane `idx` and `idx` increments.
  - On a pop with `idx`==`ratio-1`: go to HOLD, set `out_count`=`ratio`, set `out_valid`=1, and set `idx`=0.
- HOLD:
  - `fifo_read_en`=0.
  - `out_data`, `out_count` and `out_valid` stay stable until the word is accepted.
  - On acceptance: `out_valid`=0, all lanes of the packing register clear to 0, `out_count`=0, and the next state is FILL.
  - No pop happens in the accept cycle.
- Unused lanes are always 0.
- The FSM never drops, duplicates or reorders words.
- Reset asserted in the middle of operation:
  - Discards the partial word and any held word.
  - Words already popped are lost; words still in the FIFO are unaffected.

## Timing

- Reset values: `out_valid`=0, `out_data`=0, `out_count`=0, state=FILL, `idx`=0, `idle`=0. `fifo_read_en`=0 while `reset_n`=0.
- `out_data`, `out_count` and `out_valid` are registered.
- `out_valid` rises on the clock edge that completes the final pop of a word.
- With the FIFO never empty and `out_ready` held at 1, one output word is produced every `ratio+1` cycles: `ratio` pop cycles plus one accept cycle.
- Backpressure: `out_valid` stays high indefinitely while `out_ready`=0. No pops occur during that time, so the FIFO fills and asserts its own `full`.
- The FSM handles the FIFO's `empty` flag going low in the same cycle as an accept; that word is popped on the following cycle.
- Idle timer (with `PACKER_FLUSH_EN` only):
  - `idle` increments each FILL cycle where `idx`>0 and no pop occurs.
  - `idle` clears on any pop and on every state change.
  - The edge at which `idle` would reach `timeout` instead transfers the FSM to HOLD with `out_count`=`idx`, `out_valid`=1 and `idx`=0.
  - The flush therefore fires on the edge ending the `timeout`-th consecutive idle cycle.
  - `idx`==0 never flushes.

## Configuration

- Macro `PACKER_FLUSH_EN`.
- Defined: the idle timer and partial flush are built as described above, and `out_count` can take any value from 1 to `ratio`.
- Undefined:
  - No timer logic is built.
  - A partial word waits in FILL indefinitely.
  - `out_count` is always `ratio` whenever `out_valid`=1.

## Test plan

All scenarios use `width`=8, `ratio`=4, `timeout`=15.

- **Reset:** hold `reset_n`=0 with the FIFO non-empty -> `fifo_read_en`=0, `out_valid`=0, `out_data`=0, `out_count`=0.
- **Basic pack:** write 0x11, 0x22, 0x33, 0x44 into the FIFO with `out_ready`=1 -> four consecutive `fifo_read_en` pulses, then `out_data`=0x44332211 and `out_count`=4 for exactly one cycle.
- **Backpressure:** write 8 words (0x01..0x08) and hold `out_ready`=0 for 20 cycles -> `out_data`=0x04030201 stays stable and no pops occur after the 4th. Then release `out_ready` -> accept, followed by `out_data`=0x08070605.
- **Flush (macro defined):** write 0xAA, 0xBB, then keep the FIFO empty -> on the 15th idle cycle `out_data`=0x0000BBAA and `out_count`=2. With the macro undefined, `out_valid` stays 0 for 100 cycles.
- **Timer restart (macro defined):** push one word every 10 cycles -> no flush, a single packet with `out_count`=4.
- **Reset mid-fill:** pop 3 words, pulse `reset_n` low, then push 0x51..0x54 -> `out_data`=0x54535251 and `out_count`=4, with no residue from the earlier words.
